// File: rtl/hazard_ctrl_if.sv
// Decode/EX side-band bundle between the pipeline and the hazard controller.
// The pipeline is the master; hazard_ctrl is the slave that returns the controls.
interface hazard_ctrl_if;
  logic        ID_vld;
  logic [5:0]  ID_rs1;
  logic [5:0]  ID_rs2;
  logic        ID_EX_vld;
  logic [5:0]  ID_EX_rd;
  logic [3:0]  ID_EX_mem_cmd;
  logic [4:0]  ID_EX_alu_func;
  logic        EX_take_branch;

  logic        IF_stall;
  logic        ID_stall;
  logic        ID_EX_bubble;
  logic        IF_ID_flush;
  logic        EX_hold;
  logic        EX_MEM_bubble;
  logic        md_done;
  logic [31:0] stall_cnt;

  modport master (
    output ID_vld, ID_rs1, ID_rs2, ID_EX_vld, ID_EX_rd, ID_EX_mem_cmd,
           ID_EX_alu_func, EX_take_branch,
    input  IF_stall, ID_stall, ID_EX_bubble, IF_ID_flush, EX_hold,
           EX_MEM_bubble, md_done, stall_cnt
  );

  modport slave (
    input  ID_vld, ID_rs1, ID_rs2, ID_EX_vld, ID_EX_rd, ID_EX_mem_cmd,
           ID_EX_alu_func, EX_take_branch,
    output IF_stall, ID_stall, ID_EX_bubble, IF_ID_flush, EX_hold,
           EX_MEM_bubble, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use interlock, MUL/DIV EX
// occupancy, taken-branch flush, and a saturating stall-cycle counter.
`ifndef ZERO_REG
`define ZERO_REG 6'd0
`endif
`ifndef MEM_NONE
`define MEM_NONE 4'h0
`endif

module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  // ALU function encodings of the multi-cycle ops (mem_cmd[3] marks a store).
  localparam logic [4:0] ALU_MUL    = 5'h10;
  localparam logic [4:0] ALU_MULH   = 5'h11;
  localparam logic [4:0] ALU_MULHSU = 5'h12;
  localparam logic [4:0] ALU_MULHU  = 5'h13;
  localparam logic [4:0] ALU_DIV    = 5'h14;
  localparam logic [4:0] ALU_DIVU   = 5'h15;
  localparam logic [4:0] ALU_REM    = 5'h16;
  localparam logic [4:0] ALU_REMU   = 5'h17;

  localparam logic [4:0] MUL_LAT_C = 5'(MUL_LAT);
  localparam logic [4:0] DIV_LAT_C = 5'(DIV_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic       load_in_ex;
  logic       mul_in_ex;
  logic       div_in_ex;
  logic [4:0] lat;
  logic       start;
  logic       md_done_raw;
  logic       hold;
  logic       flush;
  logic       load_use;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    load_in_ex = hz.ID_EX_vld && (hz.ID_EX_mem_cmd != `MEM_NONE) && !hz.ID_EX_mem_cmd[3];
    mul_in_ex  = hz.ID_EX_vld && (hz.ID_EX_alu_func == ALU_MUL  || hz.ID_EX_alu_func == ALU_MULH ||
                                  hz.ID_EX_alu_func == ALU_MULHSU || hz.ID_EX_alu_func == ALU_MULHU);
    div_in_ex  = hz.ID_EX_vld && (hz.ID_EX_alu_func == ALU_DIV  || hz.ID_EX_alu_func == ALU_DIVU ||
                                  hz.ID_EX_alu_func == ALU_REM  || hz.ID_EX_alu_func == ALU_REMU);
    lat        = mul_in_ex ? MUL_LAT_C : DIV_LAT_C;
  end

  // Occupancy FSM: cnt counts the remaining EX cycles of the op after this one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start       = 1'b0;
    md_done_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mul_in_ex || div_in_ex) begin
          if (lat > 5'd1) begin
            start   = 1'b1;
            cnt_d   = lat - 5'd1;
            state_d = BUSY;
          end else begin
            md_done_raw = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          md_done_raw = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold     = start || (state_q == BUSY && cnt_q > 5'd1);
    flush    = hz.EX_take_branch && hz.ID_EX_vld && !hold;
    load_use = load_in_ex && hz.ID_vld && (hz.ID_EX_rd != `ZERO_REG) &&
               (hz.ID_rs1 == hz.ID_EX_rd || hz.ID_rs2 == hz.ID_EX_rd);
  end

  always_comb begin
    hz.IF_stall      = 1'b0;
    hz.ID_stall      = 1'b0;
    hz.ID_EX_bubble  = 1'b0;
    hz.IF_ID_flush   = 1'b0;
    hz.EX_hold       = 1'b0;
    hz.EX_MEM_bubble = 1'b0;
    hz.md_done       = 1'b0;
    if (!rst) begin
      hz.md_done = md_done_raw;
      if (hold) begin
        hz.IF_stall      = 1'b1;
        hz.ID_stall      = 1'b1;
        hz.EX_hold       = 1'b1;
        hz.EX_MEM_bubble = 1'b1;
      end else if (flush) begin
        hz.IF_ID_flush  = 1'b1;
        hz.ID_EX_bubble = 1'b1;
      end else if (load_use) begin
        hz.IF_stall     = 1'b1;
        hz.ID_stall     = 1'b1;
        hz.ID_EX_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz.IF_stall) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  assign hz.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_LAT=3, DIV_LAT=16) with hand-computed
// expected control vectors {IF,ID,ID_EX_bub,IF_ID_flush,EX_hold,EX_MEM_bub,md_done}.
module tb_hazard_ctrl;
  localparam logic [4:0] ALU_ADD = 5'h00;
  localparam logic [4:0] ALU_MUL = 5'h10;
  localparam logic [4:0] ALU_DIV = 5'h14;
  localparam logic [3:0] MEM_NO  = 4'h0;
  localparam logic [3:0] MEM_LW  = 4'h2;
  localparam logic [3:0] MEM_SW  = 4'hA;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_HOLD  = 7'b1100110;
  localparam logic [6:0] C_DONE  = 7'b0000001;
  localparam logic [6:0] C_LU    = 7'b1110000;
  localparam logic [6:0] C_FLUSH = 7'b0011000;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  wire [6:0] ctl = {bus.IF_stall, bus.ID_stall, bus.ID_EX_bubble, bus.IF_ID_flush,
                    bus.EX_hold, bus.EX_MEM_bubble, bus.md_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && bus.EX_take_branch && bus.EX_hold)
      $error("branch asserted during hold");

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic set_in(input logic idv, input logic [5:0] rs1, input logic [5:0] rs2,
                        input logic exv, input logic [5:0] rd, input logic [3:0] mem,
                        input logic [4:0] alu, input logic br);
    bus.ID_vld         = idv;
    bus.ID_rs1         = rs1;
    bus.ID_rs2         = rs2;
    bus.ID_EX_vld      = exv;
    bus.ID_EX_rd       = rd;
    bus.ID_EX_mem_cmd  = mem;
    bus.ID_EX_alu_func = alu;
    bus.EX_take_branch = br;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, MEM_NO, ALU_ADD, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    set_in(1, 6'd5, 6'd7, 1, 6'd5, MEM_LW, ALU_DIV, 0);
    #1;
    vec_cnt++;
    if (ctl !== C_NONE) begin
      err_cnt++; $display("FAIL reset_ctl got %b exp %b", ctl, C_NONE);
    end
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, MEM_NO, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (bus.stall_cnt !== 32'd0) begin
      err_cnt++; $display("FAIL reset_cnt got %h exp %h", bus.stall_cnt, 32'd0);
    end
    vec_cnt++;
    if (ctl !== C_NONE) begin
      err_cnt++; $display("FAIL reset_idle got %b exp %b", ctl, C_NONE);
    end
  endtask

  task automatic test_load_use;
    do_reset();
    @(negedge clk);
    set_in(1, 6'd5, 6'd7, 1, 6'd5, MEM_LW, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (ctl !== C_LU) begin
      err_cnt++; $display("FAIL lu_stall got %b exp %b", ctl, C_LU);
    end
    @(negedge clk);
    set_in(1, 6'd5, 6'd7, 0, 6'd0, MEM_NO, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (ctl !== C_NONE) begin
      err_cnt++; $display("FAIL lu_release got %b exp %b", ctl, C_NONE);
    end
    vec_cnt++;
    if (bus.stall_cnt !== 32'd1) begin
      err_cnt++; $display("FAIL lu_cnt got %0d exp %0d", bus.stall_cnt, 1);
    end
    @(negedge clk);
    set_in(1, 6'd0, 6'd7, 1, 6'd0, MEM_LW, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (ctl !== C_NONE) begin
      err_cnt++; $display("FAIL lu_x0 got %b exp %b", ctl, C_NONE);
    end
    @(negedge clk);
    set_in(1, 6'd9, 6'd5, 1, 6'd5, MEM_SW, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (ctl !== C_NONE) begin
      err_cnt++; $display("FAIL lu_store got %b exp %b", ctl, C_NONE);
    end
    @(negedge clk);
    set_in(1, 6'd9, 6'd5, 1, 6'd5, MEM_LW, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (ctl !== C_LU) begin
      err_cnt++; $display("FAIL lu_rs2 got %b exp %b", ctl, C_LU);
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, MEM_NO, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (bus.stall_cnt !== 32'd2) begin
      err_cnt++; $display("FAIL lu_cnt2 got %0d exp %0d", bus.stall_cnt, 2);
    end
  endtask

  task automatic test_mul;
    logic [6:0] exp;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_in(1, 6'd1, 6'd2, 1, 6'd3, MEM_NO, ALU_MUL, 0);
      #1;
      exp = (i < 3) ? C_HOLD : C_DONE;
      vec_cnt++;
      if (ctl !== exp) begin
        err_cnt++; $display("FAIL mul_cyc%0d got %b exp %b", i, ctl, exp);
      end
    end
    @(negedge clk);
    set_in(1, 6'd1, 6'd2, 1, 6'd4, MEM_NO, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (ctl !== C_NONE) begin
      err_cnt++; $display("FAIL mul_after got %b exp %b", ctl, C_NONE);
    end
    vec_cnt++;
    if (bus.stall_cnt !== 32'd2) begin
      err_cnt++; $display("FAIL mul_cnt got %0d exp %0d", bus.stall_cnt, 2);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      set_in(1, 6'd1, 6'd2, 1, 6'd3, MEM_NO, ALU_DIV, 0);
      #1;
      exp = (i < 16) ? C_HOLD : C_DONE;
      vec_cnt++;
      if (ctl !== exp) begin
        err_cnt++; $display("FAIL div_cyc%0d got %b exp %b", i, ctl, exp);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_in(1, 6'd1, 6'd2, 1, 6'd4, MEM_NO, ALU_MUL, 0);
      #1;
      exp = (i < 3) ? C_HOLD : C_DONE;
      vec_cnt++;
      if (ctl !== exp) begin
        err_cnt++; $display("FAIL b2b_mul_cyc%0d got %b exp %b", i, ctl, exp);
      end
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, MEM_NO, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (bus.stall_cnt !== 32'd17) begin
      err_cnt++; $display("FAIL b2b_cnt got %0d exp %0d", bus.stall_cnt, 17);
    end
  endtask

  task automatic test_branch;
    do_reset();
    @(negedge clk);
    set_in(1, 6'd5, 6'd7, 1, 6'd5, MEM_LW, ALU_ADD, 1);
    #1;
    vec_cnt++;
    if (ctl !== C_FLUSH) begin
      err_cnt++; $display("FAIL br_flush got %b exp %b", ctl, C_FLUSH);
    end
    @(negedge clk);
    set_in(1, 6'd1, 6'd2, 0, 6'd5, MEM_NO, ALU_ADD, 1);
    #1;
    vec_cnt++;
    if (ctl !== C_NONE) begin
      err_cnt++; $display("FAIL br_invalid got %b exp %b", ctl, C_NONE);
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, MEM_NO, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (bus.stall_cnt !== 32'd0) begin
      err_cnt++; $display("FAIL br_cnt got %0d exp %0d", bus.stall_cnt, 0);
    end
  endtask

  task automatic test_reset_busy;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      set_in(1, 6'd1, 6'd2, 1, 6'd3, MEM_NO, ALU_DIV, 0);
      #1;
      vec_cnt++;
      if (ctl !== C_HOLD) begin
        err_cnt++; $display("FAIL rb_div_cyc%0d got %b exp %b", i, ctl, C_HOLD);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (ctl !== C_NONE) begin
      err_cnt++; $display("FAIL rb_during_rst got %b exp %b", ctl, C_NONE);
    end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      rst = 1'b0;
      set_in(1, 6'd1, 6'd2, 1, 6'd4, MEM_NO, ALU_ADD, 0);
      #1;
      vec_cnt++;
      if (ctl !== C_NONE) begin
        err_cnt++; $display("FAIL rb_add%0d got %b exp %b", i, ctl, C_NONE);
      end
    end
    vec_cnt++;
    if (bus.stall_cnt !== 32'd0) begin
      err_cnt++; $display("FAIL rb_cnt got %0d exp %0d", bus.stall_cnt, 0);
    end
  endtask

  task automatic test_saturate;
    do_reset();
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    vec_cnt++;
    if (bus.stall_cnt !== 32'hFFFF_FFFE) begin
      err_cnt++; $display("FAIL sat_preload got %h exp %h", bus.stall_cnt, 32'hFFFF_FFFE);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_in(1, 6'd5, 6'd7, 1, 6'd5, MEM_LW, ALU_ADD, 0);
      #1;
      if (i > 1) begin
        vec_cnt++;
        if (bus.stall_cnt !== 32'hFFFF_FFFF) begin
          err_cnt++; $display("FAIL sat_cyc%0d got %h exp %h", i, bus.stall_cnt, 32'hFFFF_FFFF);
        end
      end
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, MEM_NO, ALU_ADD, 0);
    #1;
    vec_cnt++;
    if (bus.stall_cnt !== 32'hFFFF_FFFF) begin
      err_cnt++; $display("FAIL sat_final got %h exp %h", bus.stall_cnt, 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, MEM_NO, ALU_ADD, 0);
    test_reset();
    test_load_use();
    test_mul();
    test_back_to_back();
    test_branch();
    test_reset_busy();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
